dm_access_ctrl: RTL and testbench
=================================

# dm_access_ctrl

Access controller between the processor's memory-stage requesters and the 12 KB byte-array data memory (dm_12k: 14-bit byte address, 32-bit little-endian din/dout, single write enable). It arbitrates between two requesters: port 0 is the CPU MEM stage and port 1 is the loader/debug DMA. It executes word, halfword and byte loads with sign or zero extension. Sub-word stores are done as read-modify-write, because the memory writes all four bytes on every write.

## Interface
Parameters:
- MEM_BYTES, 12288: memory size in bytes. An address at or above this value is out of range.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- p0_req / p1_req  in  1  request; held stable until the matching ack
- p0_op / p1_op  in  3  operation: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- p0_addr / p1_addr  in  14  byte address
- p0_wdata / p1_wdata  in  32  store data; sub-word stores use the low bits
- p0_ack / p1_ack  out  1  one-cycle completion pulse to the granted port
- rdata  out  32  load result; valid while either ack is high; 0 for stores and errors
- err  out  1  valid while either ack is high; high when the address is misaligned or out of range
- busy  out  1  high whenever state is not IDLE
- dm_addr  out  14  word-aligned address to memory, {addr[13:2],2'b00}
- dm_din  out  32  write data to memory
- dm_we  out  1  memory write enable
- dm_dout  in  32  memory read data (combinational)

## Operation
- States: IDLE, EXEC, MERGE, RESP.
- IDLE, arbitration:
  - A single request is granted.
  - If both ports request, the grant goes to the port not granted last (round-robin).
  - A `last` register updates on every grant; it resets to 1, so port 0 wins the first tie.
  - On grant, latch op, addr and wdata, then go to EXEC.
- Error check, at grant:
  - LW/SW with addr[1:0]≠0 is an error.
  - LH/LHU/SH with addr[0]≠0 is an error.
  - addr ≥ MEM_BYTES is an error.
  - An errored request goes straight to RESP with err=1 and rdata=0. Memory is never written.
- EXEC:
  - dm_addr holds the aligned latched address.
  - Loads capture the extracted and extended dm_dout into rdata, then go to RESP.
    - Byte lane k = addr[1:0] is dm_dout[8k+7:8k].
    - Half lane h = addr[1] is dm_dout[16h+15:16h].
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - SW drives dm_din = wdata and dm_we = 1, then goes to RESP.
  - SH/SB capture dm_dout into the merge register, then go to MERGE.
- MERGE:
  - dm_din = merge register with the addressed byte or half replaced by wdata[7:0] or wdata[15:0].
  - dm_we = 1; go to RESP.
- RESP:
  - The granted port's ack = 1 for this cycle only; go to IDLE.
  - The requester drops req, or presents a new request, in the next cycle.
- Outputs are decoded from registered state. dm_we is high for exactly one cycle per store and never in IDLE, RESP or on error.
- dm_addr and dm_din hold their last values while idle. rdata and err hold until the next RESP.

## Timing
- Reset values: state IDLE, last=1, p0_ack=p1_ack=0, rdata=0, err=0, busy=0, dm_we=0, dm_addr=0, dm_din=0.
- Cycle numbering: cycle 0 is the IDLE cycle in which req is sampled.
- Latency, request to ack:
  - Load or SW: EXEC in cycle 1, ack in cycle 2.
  - SH/SB: EXEC in cycle 1, MERGE in cycle 2, ack in cycle 3.
  - Error: ack in cycle 1.
- Back-to-back: after RESP, a new request is accepted in the following IDLE cycle. Minimum spacing is 3 cycles for loads and SW, 4 for SH/SB.
- Requests arriving while busy are not sampled. They wait, and the round-robin is applied when the block returns to IDLE.
- Reset mid-operation: state returns to IDLE immediately and dm_we drops asynchronously. A store is lost unless its write edge has already occurred, and no ack is issued.

## Test plan
- Reset, then p0 SW addr 0x0010 wdata 0xDEADBEEF, then p0 LW 0x0010 -> dm_we pulses in cycle 1 with dm_addr 0x0010; LW ack in cycle 2 with rdata 0xDEADBEEF, err 0.
- With word 0xDEADBEEF at 0x0010: SB addr 0x0012 wdata 0x55 -> ack in cycle 3, word becomes 0xDE55BEEF. Then LB 0x0012 -> 0x00000055, and LBU 0x0013 -> 0x000000DE.
- LH 0x0010 on 0x8001FFFF -> 0xFFFFFFFF; LHU 0x0012 -> 0x00008001; SH 0x0012 wdata 0x1234 -> word 0x1234FFFF.
- LW 0x0011, SH 0x0013, and LW 0x3000 -> ack in cycle 1, err 1, rdata 0, dm_we never asserted; memory unchanged.
- Both ports requesting LW continuously -> grants go p0, p1, p0, p1; each ack appears only on its own port.
- rst_n low during MERGE of an SB -> dm_we drops at once, no ack, state IDLE, memory word unchanged.

Source files
------------

// File: rtl/dm_access_ctrl_if.sv
// Bus bundle between the two requesters, the access controller and dm_12k.
// The slave modport is the controller's view; master is the environment
// (requesters plus memory).
interface dm_access_ctrl_if;
    logic        p0_req;
    logic [2:0]  p0_op;
    logic [13:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_ack;

    logic        p1_req;
    logic [2:0]  p1_op;
    logic [13:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_ack;

    logic [31:0] rdata;
    logic        err;
    logic        busy;

    logic [13:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    modport slave (
        input  p0_req, p0_op, p0_addr, p0_wdata,
        input  p1_req, p1_op, p1_addr, p1_wdata,
        input  dm_dout,
        output p0_ack, p1_ack, rdata, err, busy,
        output dm_addr, dm_din, dm_we
    );

    modport master (
        output p0_req, p0_op, p0_addr, p0_wdata,
        output p1_req, p1_op, p1_addr, p1_wdata,
        output dm_dout,
        input  p0_ack, p1_ack, rdata, err, busy,
        input  dm_addr, dm_din, dm_we
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Two-port round-robin access controller for the 12 KB byte-array data
// memory. Word/half/byte loads with sign or zero extension; sub-word stores
// are read-modify-write because the memory always writes a full word.
module dm_access_ctrl #(
    parameter int unsigned MEM_BYTES = 12288
) (
    input  logic           clk,
    input  logic           rst_n,
    dm_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXEC, MERGE, RESP} state_e;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_e;

    state_e      state;
    logic        last;
    logic        gnt_port;
    op_e         op_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        gnt_valid;
    logic        gnt_sel;
    op_e         sel_op;
    logic [13:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    // Extract the addressed lane of a memory word and extend it for the load op.
    function automatic logic [31:0] load_extract(input op_e op, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0000, h};
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h000000, b};
            default: return word;
        endcase
    endfunction

    // Replace the addressed byte or half of the old word with the store data.
    function automatic logic [31:0] store_merge(input op_e op, input logic [1:0] lane,
                                                input logic [31:0] word,
                                                input logic [15:0] wd);
        logic [31:0] m;
        m = word;
        if (op == OP_SB)
            m[{lane, 3'b000} +: 8] = wd[7:0];
        else
            m[{lane[1], 4'b0000} +: 16] = wd;
        return m;
    endfunction

    // Round-robin pick between the two requesters and error check of the winner.
    always_comb begin
        gnt_valid = bus.p0_req | bus.p1_req;
        gnt_sel   = bus.p1_req & (~bus.p0_req | ~last);
        sel_op    = op_e'(gnt_sel ? bus.p1_op : bus.p0_op);
        sel_addr  = gnt_sel ? bus.p1_addr : bus.p0_addr;
        sel_wdata = gnt_sel ? bus.p1_wdata : bus.p0_wdata;
        sel_err   = 1'b0;
        case (sel_op)
            OP_LW, OP_SW:        sel_err = (sel_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: sel_err = sel_addr[0];
            default:             sel_err = 1'b0;
        endcase
        if ({18'd0, sel_addr} >= MEM_BYTES)
            sel_err = 1'b1;
    end

    // Controller FSM; every output is a register updated on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            gnt_port    <= 1'b0;
            op_q        <= OP_LW;
            lane_q      <= '0;
            wdata_q     <= '0;
            bus.p0_ack  <= 1'b0;
            bus.p1_ack  <= 1'b0;
            bus.rdata   <= '0;
            bus.err     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.dm_we   <= 1'b0;
            bus.dm_addr <= '0;
            bus.dm_din  <= '0;
        end else begin
            bus.p0_ack <= 1'b0;
            bus.p1_ack <= 1'b0;
            bus.dm_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        last     <= gnt_sel;
                        gnt_port <= gnt_sel;
                        op_q     <= sel_op;
                        lane_q   <= sel_addr[1:0];
                        wdata_q  <= sel_wdata[15:0];
                        bus.busy <= 1'b1;
                        if (sel_err) begin
                            state      <= RESP;
                            bus.rdata  <= '0;
                            bus.err    <= 1'b1;
                            bus.p0_ack <= ~gnt_sel;
                            bus.p1_ack <= gnt_sel;
                        end else begin
                            state       <= EXEC;
                            bus.dm_addr <= {sel_addr[13:2], 2'b00};
                            if (sel_op == OP_SW) begin
                                bus.dm_din <= sel_wdata;
                                bus.dm_we  <= 1'b1;
                            end
                        end
                    end
                end
                EXEC: begin
                    if (op_q == OP_SH || op_q == OP_SB) begin
                        // The merge is folded straight into dm_din here, so the
                        // MERGE cycle drives the merged word with dm_we high.
                        state      <= MERGE;
                        bus.dm_din <= store_merge(op_q, lane_q, bus.dm_dout, wdata_q);
                        bus.dm_we  <= 1'b1;
                    end else begin
                        state      <= RESP;
                        bus.rdata  <= (op_q == OP_SW) ? '0
                                      : load_extract(op_q, lane_q, bus.dm_dout);
                        bus.err    <= 1'b0;
                        bus.p0_ack <= ~gnt_port;
                        bus.p1_ack <= gnt_port;
                    end
                end
                MERGE: begin
                    state      <= RESP;
                    bus.rdata  <= '0;
                    bus.err    <= 1'b0;
                    bus.p0_ack <= ~gnt_port;
                    bus.p1_ack <= gnt_port;
                end
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: byte-array memory model, directed vector table,
// random transactions against a byte-level reference model, round-robin and
// mid-operation reset sequences.
module tb_dm_access_ctrl;

    localparam int MEM_BYTES = 12288;

    logic clk;
    logic rst_n;
    logic mem_clear;

    int n_checks;
    int n_fail;

    dm_access_ctrl_if bus ();

    dm_access_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dm_12k: combinational read, full-word write on the clock edge.
    logic [7:0] mem [0:MEM_BYTES-1];

    always_comb begin
        bus.dm_dout = '0;
        if (int'(bus.dm_addr) <= MEM_BYTES - 4)
            for (int i = 0; i < 4; i++)
                bus.dm_dout[8*i +: 8] = mem[int'(bus.dm_addr) + i];
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        end else if (bus.dm_we && int'(bus.dm_addr) <= MEM_BYTES - 4) begin
            for (int i = 0; i < 4; i++) mem[int'(bus.dm_addr) + i] <= bus.dm_din[8*i +: 8];
        end
    end

    // Reference memory: plain byte array updated by the architectural effect of each op.
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd5:       return 4;
            3'd1, 3'd2, 3'd6: return 2;
            default:          return 1;
        endcase
    endfunction

    function automatic bit is_store(input logic [2:0] op);
        return op >= 3'd5;
    endfunction

    task automatic ref_apply(input logic [2:0] op, input logic [13:0] addr,
                             input logic [31:0] wdata,
                             output logic [31:0] rd, output logic er, output int lat,
                             output int we_cnt, output int we_cyc);
        int sz;
        int a;
        longint v;
        sz = op_size(op);
        a  = int'(addr);
        er = ((a % sz) != 0) || (a >= MEM_BYTES);
        rd = '0;
        we_cnt = 0;
        we_cyc = 0;
        if (er) begin
            lat = 1;
        end else if (is_store(op)) begin
            for (int i = 0; i < sz; i++) ref_mem[a + i] = wdata[8*i +: 8];
            lat    = (sz == 4) ? 2 : 3;
            we_cnt = 1;
            we_cyc = (sz == 4) ? 1 : 2;
        end else begin
            v = 0;
            for (int i = 0; i < sz; i++) v = v + (longint'(ref_mem[a + i]) << (8 * i));
            if ((op == 3'd1 || op == 3'd3) && v >= (longint'(1) << (8 * sz - 1)))
                v = v - (longint'(1) << (8 * sz));
            rd  = v[31:0];
            lat = 2;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int port, input logic req, input logic [2:0] op,
                         input logic [13:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            bus.p0_req = req; bus.p0_op = op; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end else begin
            bus.p1_req = req; bus.p1_op = op; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end
    endtask

    // One transaction from an idle controller; cycle 0 is the IDLE cycle sampling req.
    task automatic xact(input int port, input logic [2:0] op, input logic [13:0] addr,
                        input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int we_cnt, output int we_cyc, output int other_ack);
        logic own;
        logic oth;
        rd = 'x; er = 1'bx; lat = -1; we_cnt = 0; we_cyc = 0; other_ack = 0;
        @(negedge clk);
        drive(port, 1'b1, op, addr, wdata);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            own = (port == 0) ? bus.p0_ack : bus.p1_ack;
            oth = (port == 0) ? bus.p1_ack : bus.p0_ack;
            if (oth) other_ack++;
            if (bus.dm_we) begin
                we_cnt++;
                we_cyc = c;
            end
            if (own) begin
                lat = c;
                rd  = bus.rdata;
                er  = bus.err;
                break;
            end
        end
        drive(port, 1'b0, op, addr, wdata);
    endtask

    typedef struct {
        int          port;
        logic [2:0]  op;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, we_cnt, we_cyc, oack, elat, ewe_cnt, ewe_cyc;
        int          order[$];
        int          both_ack, mism;
        logic [31:0] exp0, exp1;
        logic [2:0]  op;
        logic [13:0] addr;
        logic [31:0] wdata;
        int          port;

        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        drive(0, 1'b0, 3'd0, 14'd0, 32'd0);
        drive(1, 1'b0, 3'd0, 14'd0, 32'd0);
        mem_clear = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_p0_ack",  {31'd0, bus.p0_ack}, 32'd0);
        check("rst_p1_ack",  {31'd0, bus.p1_ack}, 32'd0);
        check("rst_rdata",   bus.rdata, 32'd0);
        check("rst_err",     {31'd0, bus.err}, 32'd0);
        check("rst_busy",    {31'd0, bus.busy}, 32'd0);
        check("rst_dm_we",   {31'd0, bus.dm_we}, 32'd0);
        check("rst_dm_addr", {18'd0, bus.dm_addr}, 32'd0);
        check("rst_dm_din",  bus.dm_din, 32'd0);

        mem_clear = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        vecs.push_back('{0, 3'd5, 14'h0010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2});
        vecs.push_back('{0, 3'd0, 14'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 2});
        vecs.push_back('{0, 3'd7, 14'h0012, 32'h00000055, 32'h00000000, 1'b0, 3});
        vecs.push_back('{0, 3'd0, 14'h0010, 32'h0,        32'hDE55BEEF, 1'b0, 2});
        vecs.push_back('{0, 3'd3, 14'h0012, 32'h0,        32'h00000055, 1'b0, 2});
        vecs.push_back('{0, 3'd4, 14'h0013, 32'h0,        32'h000000DE, 1'b0, 2});
        vecs.push_back('{1, 3'd5, 14'h0010, 32'h8001FFFF, 32'h00000000, 1'b0, 2});
        vecs.push_back('{0, 3'd1, 14'h0010, 32'h0,        32'hFFFFFFFF, 1'b0, 2});
        vecs.push_back('{1, 3'd2, 14'h0012, 32'h0,        32'h00008001, 1'b0, 2});
        vecs.push_back('{0, 3'd6, 14'h0012, 32'h00001234, 32'h00000000, 1'b0, 3});
        vecs.push_back('{0, 3'd0, 14'h0010, 32'h0,        32'h1234FFFF, 1'b0, 2});
        vecs.push_back('{0, 3'd0, 14'h0011, 32'h0,        32'h00000000, 1'b1, 1});
        vecs.push_back('{1, 3'd6, 14'h0013, 32'h0000ABCD, 32'h00000000, 1'b1, 1});
        vecs.push_back('{0, 3'd0, 14'h3000, 32'h0,        32'h00000000, 1'b1, 1});
        vecs.push_back('{0, 3'd0, 14'h0010, 32'h0,        32'h1234FFFF, 1'b0, 2});
        vecs.push_back('{0, 3'd7, 14'h3FFF, 32'h000000FF, 32'h00000000, 1'b1, 1});
        vecs.push_back('{1, 3'd7, 14'h2FFF, 32'h00000080, 32'h00000000, 1'b0, 3});
        vecs.push_back('{0, 3'd3, 14'h2FFF, 32'h0,        32'hFFFFFF80, 1'b0, 2});
        vecs.push_back('{1, 3'd4, 14'h2FFF, 32'h0,        32'h00000080, 1'b0, 2});
        vecs.push_back('{0, 3'd1, 14'h2FFE, 32'h0,        32'hFFFF8000, 1'b0, 2});
        vecs.push_back('{0, 3'd6, 14'h0011, 32'h00004321, 32'h00000000, 1'b1, 1});

        foreach (vecs[i]) begin
            xact(vecs[i].port, vecs[i].op, vecs[i].addr, vecs[i].wdata,
                 rd, er, lat, we_cnt, we_cyc, oack);
            ref_apply(vecs[i].op, vecs[i].addr, vecs[i].wdata, erd, eer, elat, ewe_cnt, ewe_cyc);
            ewe_cnt = (is_store(vecs[i].op) && !vecs[i].exp_err) ? 1 : 0;
            ewe_cyc = (ewe_cnt == 0) ? 0 : ((vecs[i].op == 3'd5) ? 1 : 2);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_we_count", i), 32'(we_cnt), 32'(ewe_cnt));
            check($sformatf("vec%0d_we_cycle", i), 32'(we_cyc), 32'(ewe_cyc));
            check($sformatf("vec%0d_other_ack", i), 32'(oack), 32'd0);
        end

        for (int n = 0; n < 80; n++) begin
            port  = int'($urandom_range(0, 1));
            op    = 3'($urandom_range(0, 7));
            addr  = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(12280, 16383))
                                                : 14'($urandom_range(0, 63));
            wdata = $urandom;
            xact(port, op, addr, wdata, rd, er, lat, we_cnt, we_cyc, oack);
            ref_apply(op, addr, wdata, erd, eer, elat, ewe_cnt, ewe_cyc);
            check($sformatf("rnd%0d_rdata op%0d a%04h", n, op, addr), rd, erd);
            check($sformatf("rnd%0d_err", n), {31'd0, er}, {31'd0, eer});
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(elat));
            check($sformatf("rnd%0d_we_count", n), 32'(we_cnt), 32'(ewe_cnt));
            check($sformatf("rnd%0d_we_cycle", n), 32'(we_cyc), 32'(ewe_cyc));
            check($sformatf("rnd%0d_other_ack", n), 32'(oack), 32'd0);
        end

        // Round-robin: reset puts last at port 1, so port 0 wins the first tie.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_apply(3'd0, 14'h0010, 32'd0, exp0, eer, elat, ewe_cnt, ewe_cyc);
        ref_apply(3'd0, 14'h0020, 32'd0, exp1, eer, elat, ewe_cnt, ewe_cyc);
        @(negedge clk);
        drive(0, 1'b1, 3'd0, 14'h0010, 32'd0);
        drive(1, 1'b1, 3'd0, 14'h0020, 32'd0);
        both_ack = 0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            if (bus.p0_ack && bus.p1_ack) both_ack++;
            if (bus.p0_ack) begin
                order.push_back(0);
                check("rr_p0_rdata", bus.rdata, exp0);
            end
            if (bus.p1_ack) begin
                order.push_back(1);
                check("rr_p1_rdata", bus.rdata, exp1);
            end
        end
        drive(0, 1'b0, 3'd0, 14'h0010, 32'd0);
        drive(1, 1'b0, 3'd0, 14'h0020, 32'd0);
        check("rr_ack_count", 32'(order.size()), 32'd4);
        check("rr_both_ack", 32'(both_ack), 32'd0);
        for (int i = 0; i < order.size(); i++)
            check($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(i % 2));
        repeat (2) @(negedge clk);

        // Reset during MERGE of an SB: the write must not land and no ack follows.
        @(negedge clk);
        drive(0, 1'b1, 3'd7, 14'h0021, 32'h000000AA);
        @(negedge clk);
        check("mr_busy_exec", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check("mr_we_in_merge", {31'd0, bus.dm_we}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_we_dropped", {31'd0, bus.dm_we}, 32'd0);
        check("mr_busy_cleared", {31'd0, bus.busy}, 32'd0);
        drive(0, 1'b0, 3'd7, 14'h0021, 32'h000000AA);
        @(negedge clk);
        rst_n = 1'b1;
        oack = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.p0_ack || bus.p1_ack || bus.dm_we) oack++;
        end
        check("mr_no_ack_after_reset", 32'(oack), 32'd0);
        check("mr_word_unchanged",
              {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]},
              {ref_mem[16'h23], ref_mem[16'h22], ref_mem[16'h21], ref_mem[16'h20]});

        mism = 0;
        for (int i = 0; i < MEM_BYTES; i++)
            if (mem[i] !== ref_mem[i]) mism++;
        check("final_memory_bytes_differing", 32'(mism), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
